mips_reset_sequencer: RTL

- Power-on and soft-reset controller for the MIPS core.
- Converts a raw `initiate` start event into an ordered bring-up: reset stretch, memory init handshake, register-file clear handshake, then staged release of core reset and PC enable.
- Sits between the board-level start signal and the CPU top.
- Drives the core's active-high `reset` and gates PC advance; reports `ready`/`fault` to the top level.

---
 rtl/mips_ctrl_pkg.sv | 59 +++++
 rtl/mips_reset_sequencer_edge_sync.sv | 40 ++++
 rtl/mips_reset_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and defaults for the MIPS core control blocks.
package mips_ctrl_pkg;

   // Bring-up sequencer states; the encodings are visible on seq_state for debug.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_STRETCH  = 3'd1,
      ST_MEM_INIT = 3'd2,
      ST_RF_CLEAR = 3'd3,
      ST_RELEASE  = 3'd4,
      ST_RUN      = 3'd5,
      ST_FAULT    = 3'd6
   } seq_state_t;

   // Registered sequencer outputs, grouped so they are decoded in one place.
   typedef struct packed {
      logic core_reset;
      logic mem_init_req;
      logic rf_clear_req;
      logic pc_enable;
      logic ready;
      logic fault;
   } seq_out_t;

   localparam int unsigned DEF_STRETCH_CYCLES = 16;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
   localparam int unsigned DEF_RELEASE_GAP    = 2;

   // Largest of three bounds, used to size the shared counter.
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Output levels owned by each state; core reset is held everywhere except RELEASE and RUN.
   function automatic seq_out_t decode_outputs(input seq_state_t st);
      seq_out_t o;
      o            = '0;
      o.core_reset = 1'b1;
      case (st)
         ST_MEM_INIT: o.mem_init_req = 1'b1;
         ST_RF_CLEAR: o.rf_clear_req = 1'b1;
         ST_RELEASE:  o.core_reset   = 1'b0;
         ST_RUN: begin
            o.core_reset = 1'b0;
            o.pc_enable  = 1'b1;
            o.ready      = 1'b1;
         end
         ST_FAULT:    o.fault        = 1'b1;
         default:     ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mips_reset_sequencer_edge_sync.sv
// Two-flop synchronizer with rising-edge detect for an asynchronous board input.
// A rise only counts once the synchronized input has been seen low after reset,
// so a level already high when reset releases never produces an edge.
module edge_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic rise
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic fill1_q;
   logic fill2_q;
   logic armed_q;

   // Synchronize, remember the previous sample, and arm on the first genuine low sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         prev_q  <= 1'b0;
         fill1_q <= 1'b0;
         fill2_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so each stage captures its predecessor's value from before the edge.
         meta_q  <= din;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         fill1_q <= 1'b1;
         fill2_q <= fill1_q;
         if (fill2_q && !sync_q) armed_q <= 1'b1;
      end
   end

   assign rise = sync_q & ~prev_q & armed_q;

endmodule

// File: rtl/mips_reset_sequencer.sv
// Power-on / soft-reset sequencer for the MIPS core: reset stretch, memory init
// and register-file clear handshakes, then staged release of core reset and PC enable.
module mips_reset_sequencer
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned STRETCH_CYCLES = DEF_STRETCH_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned RELEASE_GAP    = DEF_RELEASE_GAP
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       initiate,
   input  logic       soft_reset,
   input  logic       mem_init_done,
   input  logic       rf_clear_done,
   output logic       core_reset,
   output logic       mem_init_req,
   output logic       rf_clear_req,
   output logic       pc_enable,
   output logic       ready,
   output logic       fault,
   output logic [2:0] seq_state
);

   localparam int unsigned CNT_MAX = max3(STRETCH_CYCLES, TIMEOUT_CYCLES, RELEASE_GAP);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   // Last cycle count of each timed state; the transition fires on that cycle.
   localparam cnt_t STRETCH_LAST = cnt_t'(STRETCH_CYCLES - 1);
   localparam cnt_t TIMEOUT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);
   localparam cnt_t RELEASE_LAST = cnt_t'(RELEASE_GAP - 1);

   seq_state_t state_q;
   seq_state_t state_d;
   cnt_t       cnt_q;
   cnt_t       cnt_d;
   seq_out_t   out_q;
   logic       init_rise;

   edge_sync u_init_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (initiate),
      .rise    (init_rise)
   );

   // Next state and shared counter; the counter restarts at zero on every state change.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         ST_IDLE:     if (init_rise) state_d = ST_STRETCH;
         ST_STRETCH:  if (cnt_q == STRETCH_LAST) state_d = ST_MEM_INIT;
         ST_MEM_INIT: begin
            if (mem_init_done)              state_d = ST_RF_CLEAR;
            else if (cnt_q == TIMEOUT_LAST) state_d = ST_FAULT;
         end
         ST_RF_CLEAR: begin
            if (rf_clear_done)              state_d = ST_RELEASE;
            else if (cnt_q == TIMEOUT_LAST) state_d = ST_FAULT;
         end
         ST_RELEASE:  if (cnt_q == RELEASE_LAST) state_d = ST_RUN;
         ST_RUN:      if (soft_reset) state_d = ST_STRETCH;
         ST_FAULT:    if (init_rise) state_d = ST_STRETCH;
         default:     state_d = ST_IDLE;
      endcase
      if (state_d == state_q &&
          state_q inside {ST_STRETCH, ST_MEM_INIT, ST_RF_CLEAR, ST_RELEASE}) begin
         cnt_d = cnt_q + cnt_t'(1);
      end
   end

   // State, counter and outputs; outputs are registered from the next state so they align with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         out_q   <= decode_outputs(ST_IDLE);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= decode_outputs(state_d);
      end
   end

   assign core_reset   = out_q.core_reset;
   assign mem_init_req = out_q.mem_init_req;
   assign rf_clear_req = out_q.rf_clear_req;
   assign pc_enable    = out_q.pc_enable;
   assign ready        = out_q.ready;
   assign fault        = out_q.fault;
   assign seq_state    = state_q;

endmodule
